tb_prefetch_server: RTL

//  Responder side of the traceback prefetch protocol. It services prefetch_request pulses from
//  the traceback engine and streams the matching S/T base window into the current or prefetch

---
 rtl/tb_prefetch_server_pkg.sv | 32 +++
 rtl/tb_seq_fetch_lane.sv | 47 ++++
 rtl/tb_prefetch_server.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/tb_prefetch_server_pkg.sv
//==============================================================================
// tb_prefetch_server_pkg: shared widths, request encodings and FSM states
// Rev 1.0
//==============================================================================
`default_nettype none

package tb_prefetch_server_pkg;

  localparam int BP_WIDTH       = 2;
  localparam int POSITION_WIDTH = 16;
  localparam int PREFETCH_WIDTH = 5;

  localparam logic [BP_WIDTH-1:0] DEF_PAD_BP = {BP_WIDTH{1'b1}};

  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam logic [1:0] REQ_CUR  = 2'b01;
  localparam logic [1:0] REQ_PRE  = 2'b10;
  localparam logic [1:0] REQ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic req_is_valid(input logic [1:0] req);
    return (req == REQ_CUR) || (req == REQ_PRE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tb_seq_fetch_lane.sv
//==============================================================================
// tb_seq_fetch_lane: backward address walk, pad-flag stage and pad mux, one lane
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_seq_fetch_lane #(
  parameter int               BP_W   = 2,
  parameter int               POS_W  = 16,
  parameter int               IDX_W  = 5,
  parameter logic [BP_W-1:0]  PAD_BP = {BP_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic [POS_W-1:0]  base_i,
  input  logic [IDX_W-1:0]  off_i,
  input  logic              issue_i,
  input  logic              wr_en_i,
  input  logic [BP_W-1:0]   rd_data_i,
  output logic              rd_en_o,
  output logic [POS_W-1:0]  rd_addr_o,
  output logic [BP_W-1:0]   wr_data_o
);

  logic [POS_W-1:0] w_off_ext;
  logic             pad_d;
  logic             pad_q;

  assign w_off_ext = {{(POS_W-IDX_W){1'b0}}, off_i};
  // Positions before sequence start are never read; the lane substitutes PAD_BP.
  assign pad_d     = (base_i < w_off_ext);
  assign rd_en_o   = issue_i & ~pad_d;
  assign rd_addr_o = issue_i ? (base_i - w_off_ext) : '0;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      pad_q <= 1'b0;
    end else if (issue_i) begin
      pad_q <= pad_d;
    end
  end

  assign wr_data_o = !wr_en_i ? '0 : (pad_q ? PAD_BP : rd_data_i);

endmodule

`default_nettype wire

// File: rtl/tb_prefetch_server.sv
//==============================================================================
// tb_prefetch_server: serves traceback prefetch requests by streaming S/T windows
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_prefetch_server
  import tb_prefetch_server_pkg::*;
#(
  parameter int               BP_W   = BP_WIDTH,
  parameter int               POS_W  = POSITION_WIDTH,
  parameter int               IDX_W  = PREFETCH_WIDTH,
  parameter logic [BP_W-1:0]  PAD_BP = {BP_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic [1:0]        prefetch_request,
  input  logic [POS_W-1:0]  in_block_x_startpoint,
  input  logic [POS_W-1:0]  in_block_y_startpoint,
  input  logic [POS_W-1:0]  prefetch_x_startpoint,
  input  logic [POS_W-1:0]  prefetch_y_startpoint,
  input  logic              tb_done,
  output logic              s_rd_en,
  output logic              t_rd_en,
  output logic [POS_W-1:0]  s_rd_addr,
  output logic [POS_W-1:0]  t_rd_addr,
  input  logic [BP_W-1:0]   s_rd_data,
  input  logic [BP_W-1:0]   t_rd_data,
  output logic              blk_wr_en,
  output logic              blk_sel,
  output logic [IDX_W-1:0]  blk_wr_idx,
  output logic [BP_W-1:0]   blk_s_data,
  output logic [BP_W-1:0]   blk_t_data,
  output logic              srv_busy,
  output logic              srv_done,
  output logic              req_err
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  off_q, off_d;
  logic              cur_sel_q, cur_sel_d;
  logic [POS_W-1:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic              pend_vld_q, pend_vld_d, pend_sel_q, pend_sel_d;
  logic [POS_W-1:0]  pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic              err_q, err_d;
  logic              wr_vld_q, wr_vld_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;

  logic              w_req_ok, w_req_bad, w_new_sel, w_issue;
  logic [POS_W-1:0]  w_new_x, w_new_y;

  // tb_done overrides everything, including a request in the same cycle.
  assign w_req_ok  = ~tb_done & req_is_valid(prefetch_request);
  assign w_req_bad = ~tb_done & (prefetch_request == REQ_BAD);
  assign w_new_sel = (prefetch_request == REQ_PRE);
  assign w_new_x   = w_new_sel ? prefetch_x_startpoint : in_block_x_startpoint;
  assign w_new_y   = w_new_sel ? prefetch_y_startpoint : in_block_y_startpoint;
  assign w_issue   = (state_q == ST_ISSUE) & ~tb_done;

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    cur_sel_d  = cur_sel_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    pend_vld_d = pend_vld_q;
    pend_sel_d = pend_sel_q;
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    err_d      = err_q | w_req_bad;
    wr_vld_d   = w_issue;
    wr_idx_d   = w_issue ? ~off_q : wr_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          // Pending slot is consumed now, so a new request can refill it.
          state_d    = ST_ISSUE;
          off_d      = '0;
          cur_sel_d  = pend_sel_q;
          cur_x_d    = pend_x_q;
          cur_y_d    = pend_y_q;
          pend_vld_d = w_req_ok;
          if (w_req_ok) begin
            pend_sel_d = w_new_sel;
            pend_x_d   = w_new_x;
            pend_y_d   = w_new_y;
          end
        end else if (w_req_ok) begin
          state_d   = ST_ISSUE;
          off_d     = '0;
          cur_sel_d = w_new_sel;
          cur_x_d   = w_new_x;
          cur_y_d   = w_new_y;
        end
      end
      ST_ISSUE: begin
        off_d = off_q + IDX_W'(1);
        if (&off_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && w_req_ok) begin
      if (pend_vld_q) begin
        err_d = 1'b1;
      end else begin
        pend_vld_d = 1'b1;
        pend_sel_d = w_new_sel;
        pend_x_d   = w_new_x;
        pend_y_d   = w_new_y;
      end
    end

    if (tb_done) begin
      state_d    = ST_IDLE;
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      off_q      <= '0;
      cur_sel_q  <= 1'b0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      pend_vld_q <= 1'b0;
      pend_sel_q <= 1'b0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      err_q      <= 1'b0;
      wr_vld_q   <= 1'b0;
      wr_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      cur_sel_q  <= cur_sel_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      pend_vld_q <= pend_vld_d;
      pend_sel_q <= pend_sel_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      err_q      <= err_d;
      wr_vld_q   <= wr_vld_d;
      wr_idx_q   <= wr_idx_d;
    end
  end

  assign blk_wr_en  = wr_vld_q & ~tb_done;
  assign srv_done   = blk_wr_en & (wr_idx_q == '0);
  assign blk_wr_idx = wr_idx_q;
  assign blk_sel    = cur_sel_q;
  assign srv_busy   = (state_q != ST_IDLE);
  assign req_err    = err_q;

  tb_seq_fetch_lane #(.BP_W(BP_W), .POS_W(POS_W), .IDX_W(IDX_W), .PAD_BP(PAD_BP)) u_lane_s (
    .clk(clk), .reset_i(reset_i), .base_i(cur_x_q), .off_i(off_q), .issue_i(w_issue),
    .wr_en_i(blk_wr_en), .rd_data_i(s_rd_data), .rd_en_o(s_rd_en), .rd_addr_o(s_rd_addr),
    .wr_data_o(blk_s_data)
  );

  tb_seq_fetch_lane #(.BP_W(BP_W), .POS_W(POS_W), .IDX_W(IDX_W), .PAD_BP(PAD_BP)) u_lane_t (
    .clk(clk), .reset_i(reset_i), .base_i(cur_y_q), .off_i(off_q), .issue_i(w_issue),
    .wr_en_i(blk_wr_en), .rd_data_i(t_rd_data), .rd_en_o(t_rd_en), .rd_addr_o(t_rd_addr),
    .wr_data_o(blk_t_data)
  );

endmodule

`default_nettype wire
